// File: rtl/fb_arb_pkg.sv
// Shared types and helpers for the framebuffer port arbiter.
// Holds the RMW FSM states, the read tag format and byte-lane helpers.
package fb_arb_pkg;

    localparam int unsigned FB_AW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StMerge,
        StWr,
        StDone
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic is_vga;
    } rd_tag_t;

    // Big-endian view mirrors the byte offset within the word.
    function automatic logic [1:0] lane_sel(logic [1:0] offset, logic swap);
        return swap ? (2'd3 - offset) : offset;
    endfunction

    function automatic logic [31:0] merge_byte(logic [31:0] word, logic [1:0] lane,
                                               logic [7:0] wbyte);
        logic [31:0] merged;
        merged = word;
        merged[{lane, 3'b000} +: 8] = wbyte;
        return merged;
    endfunction

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Tag shift register matching the RAM read latency; steers ram_q to the VGA
// port or flags it as the RMW read result when the tag reaches the end.
module fb_rd_tag_pipe
    import fb_arb_pkg::*;
#(
    parameter int unsigned RAM_RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic        issue_is_vga,
    input  logic [31:0] ram_q,
    output logic        vga_rvalid,
    output logic [31:0] vga_rdata,
    output logic        rmw_rvalid
);

    rd_tag_t pipe_q [RAM_RD_LAT];
    rd_tag_t tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RAM_RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0].valid  <= issue_valid;
            pipe_q[0].is_vga <= issue_is_vga;
            for (int unsigned i = 1; i < RAM_RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail       = pipe_q[RAM_RD_LAT-1];
    assign vga_rvalid = tail.valid & tail.is_vga;
    assign vga_rdata  = vga_rvalid ? ram_q : 32'h0;
    assign rmw_rvalid = tail.valid & ~tail.is_vga;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM scheduler: VGA scan-out reads vs. byte RMW write-back.
// Defining FB_PERF_CNT_EN adds saturating wr_count / stall_count output ports.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned RAM_RD_LAT = 2,
    parameter int unsigned AW         = FB_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_rvalid,
    output logic [31:0]   vga_rdata,
    input  logic          wr_req,
    input  logic [AW+1:0] wr_baddr,
    input  logic [7:0]    wr_byte,
    input  logic          byte_swap,
    output logic          wr_done,
    output logic          vga_miss,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_d,
    output logic          ram_we,
    input  logic [31:0]   ram_q
`ifdef FB_PERF_CNT_EN
    ,
    output logic [15:0]   wr_count,
    output logic [15:0]   stall_count
`endif
);

    arb_state_e    state_q, state_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic          miss_q, miss_d;
    logic [AW-1:0] addr_q;
    logic [1:0]    lane_q;
    logic [7:0]    byte_q;
    logic [31:0]   data_q;

    logic          grant_vga, grant_wr, grant_rd;
    logic [AW-1:0] vga_gnt_addr;
    logic          rmw_rvalid;

    // Pending VGA beats everything; a committed WR beats a fresh vga_req, which then waits.
    always_comb begin
        grant_vga    = 1'b0;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        vga_gnt_addr = '0;
        pend_d       = 1'b0;
        pend_addr_d  = pend_addr_q;
        miss_d       = miss_q;
        if (pend_q) begin
            grant_vga    = 1'b1;
            vga_gnt_addr = pend_addr_q;
            if (vga_req) begin
                miss_d = 1'b1;
            end
        end else if (state_q == StWr) begin
            grant_wr = 1'b1;
            if (vga_req) begin
                pend_d      = 1'b1;
                pend_addr_d = vga_addr;
            end
        end else if (vga_req) begin
            grant_vga    = 1'b1;
            vga_gnt_addr = vga_addr;
        end else if (state_q == StRd) begin
            grant_rd = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (wr_req) state_d = StRd;
            StRd:    if (grant_rd) state_d = StWait;
            StWait:  if (rmw_rvalid) state_d = StMerge;
            StMerge: state_d = StWr;
            StWr:    if (grant_wr) state_d = wr_req ? StDone : StIdle;
            StDone:  if (!wr_req) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            miss_q      <= 1'b0;
            addr_q      <= '0;
            lane_q      <= 2'd0;
            byte_q      <= 8'h0;
            data_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            miss_q      <= miss_d;
            if (state_q == StIdle && wr_req) begin
                addr_q <= wr_baddr[AW+1:2];
                lane_q <= lane_sel(wr_baddr[1:0], byte_swap);
                byte_q <= wr_byte;
            end
            if (state_q == StWait && rmw_rvalid) begin
                data_q <= ram_q;
            end else if (state_q == StMerge) begin
                data_q <= merge_byte(data_q, lane_q, byte_q);
            end
        end
    end

    fb_rd_tag_pipe #(
        .RAM_RD_LAT (RAM_RD_LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (grant_vga | grant_rd),
        .issue_is_vga (grant_vga),
        .ram_q        (ram_q),
        .vga_rvalid   (vga_rvalid),
        .vga_rdata    (vga_rdata),
        .rmw_rvalid   (rmw_rvalid)
    );

    assign ram_we   = grant_wr;
    assign ram_d    = grant_wr ? data_q : 32'h0;
    assign ram_addr = grant_vga ? vga_gnt_addr : ((grant_wr | grant_rd) ? addr_q : '0);
    assign wr_done  = (state_q == StDone);
    assign vga_miss = miss_q;

`ifdef FB_PERF_CNT_EN
    logic [15:0] wr_count_q, stall_count_q;
    logic        stall;

    assign stall = ((state_q == StRd) && !grant_rd) || ((state_q == StWr) && !grant_wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q    <= 16'h0;
            stall_count_q <= 16'h0;
        end else begin
            if (grant_wr && wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (stall && stall_count_q != 16'hFFFF) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign wr_count    = wr_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: directed RMW/VGA scenarios plus randomized
// VGA traffic checked against a word-level memory model and request-timing scoreboard.
module tb_fb_port_arbiter;

    localparam int unsigned LAT = 2;
    localparam int unsigned AW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_rvalid;
    logic [31:0]   vga_rdata;
    logic          wr_req = 1'b0;
    logic [AW+1:0] wr_baddr = '0;
    logic [7:0]    wr_byte = 8'h0;
    logic          byte_swap = 1'b0;
    logic          wr_done;
    logic          vga_miss;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_d;
    logic          ram_we;
    logic [31:0]   ram_q;

    always #5 clk = ~clk;

    fb_port_arbiter #(
        .RAM_RD_LAT (LAT),
        .AW         (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .wr_req     (wr_req),
        .wr_baddr   (wr_baddr),
        .wr_byte    (wr_byte),
        .byte_swap  (byte_swap),
        .wr_done    (wr_done),
        .vga_miss   (vga_miss),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .ram_q      (ram_q)
    );

    function automatic logic [31:0] init_word(int a);
        if (a < 4) return 32'h11223344;
        return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    // RAM: address sampled at the grant edge, data appears LAT cycles after the grant cycle.
    logic [31:0] mem [0:255];
    logic        mem_init = 1'b0;
    logic [31:0] rdp [LAT];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_d;
        end
        rdp[0] <= mem[ram_addr[7:0]];
        for (int i = 1; i < LAT; i++) rdp[i] <= rdp[i-1];
    end
    assign ram_q = rdp[LAT-1];

    // Reference model state
    logic [31:0] ref_mem [int];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          we_cyc = 0;
    logic [31:0] we_addr = '0;
    logic [31:0] we_data = '0;
    bit          done_seen = 1'b0;
    int          vq_addr [$];
    int          vq_due [$];
    bit          pend_prev = 1'b0;
    bit          exp_miss = 1'b0;
    int          vga_pct = 0;
    int          last_vga = -10;

    function automatic logic [31:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] expect_merge(logic [31:0] old, int off, bit swap,
                                                 logic [7:0] b);
        int          lane;
        logic [31:0] mask;
        lane = swap ? 3 - off : off;
        mask = 32'hFF << (8 * lane);
        return (old & ~mask) | ({24'h0, b} << (8 * lane));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then optionally drive random VGA traffic.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            vq_addr.delete();
            vq_due.delete();
            pend_prev = 1'b0;
            exp_miss  = 1'b0;
            chk("rst_flags", {28'h0, ram_we, wr_done, vga_rvalid, vga_miss}, 32'h0);
            chk("rst_ram_addr", 32'(ram_addr), 32'h0);
            chk("rst_ram_d", ram_d, 32'h0);
            chk("rst_rdata", vga_rdata, 32'h0);
        end else begin
            if (ram_we) begin
                we_cnt++;
                we_cyc  = cyc;
                we_addr = 32'(ram_addr);
                we_data = ram_d;
            end
            done_seen = wr_done;
            chk("vga_miss", 32'(vga_miss), 32'(exp_miss));
            if (vq_due.size() > 0 && vq_due[0] == cyc) begin
                chk("rvalid", 32'(vga_rvalid), 32'h1);
                chk("rdata", vga_rdata, ref_rd(vq_addr[0]));
                void'(vq_due.pop_front());
                void'(vq_addr.pop_front());
            end else begin
                chk("no_rvalid", 32'(vga_rvalid), 32'h0);
            end
            if (vga_req) begin
                if (pend_prev) begin
                    exp_miss = 1'b1;
                end else begin
                    vq_addr.push_back(int'(vga_addr));
                    vq_due.push_back(cyc + LAT + (ram_we ? 1 : 0));
                end
            end
            pend_prev = vga_req && ram_we && !pend_prev;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (vga_pct > 0) begin
            vga_req = 1'b0;
            if (cyc - last_vga >= 2 && $urandom_range(99) < vga_pct) begin
                vga_req  = 1'b1;
                vga_addr = AW'(64 + $urandom_range(63));
                last_vga = cyc;
            end
        end
    endtask

    // exp_lat < 0 skips the timing checks (used under random VGA contention).
    task automatic do_write(input logic [AW+1:0] baddr, input logic [7:0] b, input bit swap,
                            input logic [15:0] vmask, input int exp_lat);
        int          c0;
        int          k;
        int          w;
        logic [31:0] exp;
        w   = int'(baddr >> 2);
        exp = expect_merge(ref_rd(w), int'(baddr[1:0]), swap, b);
        wr_baddr  = baddr;
        wr_byte   = b;
        byte_swap = swap;
        wr_req    = 1'b1;
        we_cnt    = 0;
        done_seen = 1'b0;
        c0        = cyc;
        for (k = 0; k < 60 && !done_seen; k++) begin
            if (vga_pct == 0) begin
                vga_req  = (k < 16) ? vmask[k] : 1'b0;
                vga_addr = 16'h0080;
            end
            if (k == 2) begin
                wr_baddr  = baddr ^ 18'h7;
                wr_byte   = ~b;
                byte_swap = ~swap;
            end
            tick();
        end
        if (vga_pct == 0) vga_req = 1'b0;
        chk("wr_done_seen", 32'(done_seen), 32'h1);
        chk("we_pulses", 32'(we_cnt), 32'h1);
        chk("we_addr", we_addr, 32'(w));
        chk("we_data", we_data, exp);
        if (exp_lat >= 0) begin
            chk("we_latency", 32'(we_cyc - c0), 32'(exp_lat));
            chk("done_latency", 32'(k - 1), 32'(exp_lat + 1));
        end
        ref_mem[w] = exp;
        wr_req = 1'b0;
        tick();
        tick();
        chk("done_drop", 32'(wr_done), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        do_write(18'h00005, 8'hAB, 1'b0, 16'h0000, 5);
        chk("t1_literal", we_data, 32'h1122AB44);
        do_write(18'h00009, 8'hAB, 1'b1, 16'h0000, 5);
        chk("t2_literal", we_data, 32'h11AB3344);

        // Read back a freshly written word
        vga_req  = 1'b1;
        vga_addr = 16'h0001;
        tick();
        vga_req = 1'b0;
        repeat (4) tick();

        // VGA in WR cycle is deferred; VGA in RD cycle delays the RMW read
        do_write(18'h00020, 8'h5A, 1'b0, 16'h0020, 5);
        repeat (4) tick();
        do_write(18'h00031, 8'hC7, 1'b1, 16'h0002, 6);
        repeat (4) tick();

        // Second request while one is pending is lost; miss is sticky
        do_write(18'h00040, 8'h3C, 1'b0, 16'h0060, 5);
        repeat (4) tick();
        do_write(18'h0004E, 8'h99, 1'b1, 16'h0000, 5);
        chk("miss_sticky", 32'(vga_miss), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("miss_cleared", 32'(vga_miss), 32'h0);

        // Reset while the RMW read is in flight
        wr_baddr = 18'h00044;
        wr_byte  = 8'hEE;
        wr_req   = 1'b1;
        repeat (3) tick();
        we_cnt = 0;
        rst_n  = 1'b0;
        wr_req = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("rst_no_write", 32'(we_cnt), 32'h0);
        chk("rst_no_done", 32'(wr_done), 32'h0);
        do_write(18'h00044, 8'h77, 1'b0, 16'h0000, 5);

        // Scan-out every 2 cycles with back-to-back writes, then random traffic
        vga_pct = 100;
        for (int i = 0; i < 6; i++) begin
            do_write(AW'($urandom_range(255)), 8'($urandom), 1'($urandom), 16'h0, -1);
        end
        vga_pct = 40;
        for (int i = 0; i < 20; i++) begin
            do_write(AW'($urandom_range(255)), 8'($urandom), 1'($urandom), 16'h0, -1);
            repeat ($urandom_range(3)) tick();
        end
        vga_pct = 0;
        vga_req = 1'b0;
        repeat (8) tick();
        chk("vga_drain", 32'(vq_due.size()), 32'h0);
        chk("no_miss_random", 32'(vga_miss), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
